// File: rtl/regfile_multiport_pkg.sv
// Shared constants and clear-sequencer state encoding for the multi-port register file.
package regfile_multiport_pkg;

    localparam int unsigned REG_IDX_WIDTH = 5;
    localparam int unsigned WORD_LEN      = 32;
    localparam int unsigned REG_COUNT     = 2 ** REG_IDX_WIDTH;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_BUSY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read lane: write-first bypass across all write ports, highest port index winning,
// with the result forced to zero for register 0 or while the clear sequencer runs.
module regfile_bypass_mux
    import regfile_multiport_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD_LEN,
    parameter int unsigned ADDR_WIDTH = REG_IDX_WIDTH,
    parameter int unsigned NUM_WRITE  = 2
) (
    input  logic [ADDR_WIDTH-1:0]           read_addr_i,
    input  logic [DATA_WIDTH-1:0]           stored_data_i,
    input  logic                            busy_i,
    input  logic [NUM_WRITE-1:0]            write_enable_i,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_addr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data_i,
    output logic [DATA_WIDTH-1:0]           read_data_o
);

    always_comb begin
        read_data_o = stored_data_i;
        // Ascending scan so the last (highest) matching port overrides, mirroring commit order.
        for (int unsigned p = 0; p < NUM_WRITE; p++) begin
            if (write_enable_i[p] &&
                write_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == read_addr_i) begin
                read_data_o = write_data_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (busy_i || read_addr_i == '0) begin
            read_data_o = '0;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with write-first bypass and a hardware clear sequencer.
// Optional macro REGFILE_TRACE_EN prints each committed write as "x<addr> = <data>".
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD_LEN,
    parameter int unsigned ADDR_WIDTH = REG_IDX_WIDTH,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  readAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  readData,
    input  logic [NUM_WRITE-1:0]            writeEnable,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] writeAddr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] writeData,
    output logic                            busy
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_WIDTH-1:0] mem_q [NumRegs];
    logic [DATA_WIDTH-1:0] mem_d [NumRegs];

    // Clear FSM: state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= CLR_BUSY;
            clr_idx_q <= ADDR_WIDTH'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Clear FSM: next state.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLR_BUSY) begin
            clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
            if (clr_idx_q == '1) begin
                state_d = CLR_IDLE;
            end
        end
    end

    // Clear FSM: outputs.
    always_comb begin
        busy = (state_q == CLR_BUSY);
    end

    // Entry 0 is never written; its read lane is forced to zero instead.
    always_comb begin
        mem_d = mem_q;
        if (rstn) begin
            if (busy) begin
                mem_d[clr_idx_q] = '0;
            end else begin
                for (int unsigned p = 0; p < NUM_WRITE; p++) begin
                    if (writeEnable[p] && writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
                        mem_d[writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH]] =
                            writeData[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        regfile_bypass_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_WRITE  (NUM_WRITE)
        ) u_bypass_mux (
            .read_addr_i    (readAddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .stored_data_i  (mem_q[readAddr[i*ADDR_WIDTH +: ADDR_WIDTH]]),
            .busy_i         (busy),
            .write_enable_i (writeEnable),
            .write_addr_i   (writeAddr),
            .write_data_i   (writeData),
            .read_data_o    (readData[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifdef REGFILE_TRACE_EN
    // A port commits unless a higher-index enabled port targets the same address.
    function automatic logic port_commits(int unsigned p);
        if (!writeEnable[p] || writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
            return 1'b0;
        end
        for (int unsigned q = p + 1; q < NUM_WRITE; q++) begin
            if (writeEnable[q] &&
                writeAddr[q*ADDR_WIDTH +: ADDR_WIDTH] == writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rstn && !busy) begin
            for (int unsigned p = 0; p < NUM_WRITE; p++) begin
                if (port_commits(p)) begin
                    $display("x%d = %h", writeAddr[p*ADDR_WIDTH +: ADDR_WIDTH],
                             writeData[p*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport with default parameters.
module tb_regfile_multiport;

    logic        clk;
    logic        rstn;
    logic [9:0]  readAddr;
    logic [63:0] readData;
    logic [1:0]  writeEnable;
    logic [9:0]  writeAddr;
    logic [63:0] writeData;
    logic        busy;

    int total;
    int bad;

    regfile_multiport dut (
        .clk         (clk),
        .rstn        (rstn),
        .readAddr    (readAddr),
        .readData    (readData),
        .writeEnable (writeEnable),
        .writeAddr   (writeAddr),
        .writeData   (writeData),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input logic [4:0] a0, input logic [4:0] a1);
        readAddr = {a1, a0};
        #1;
    endtask

    task automatic set_write(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                             input logic [4:0] a1, input logic [31:0] d1);
        writeEnable = we;
        writeAddr   = {a1, a0};
        writeData   = {d1, d0};
    endtask

    task automatic test_reset();
        int cycles;
        rstn = 1'b0;
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        repeat (3) tick();
        rstn = 1'b1;
        set_write(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        set_read(5'd5, 5'd5);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL reset_busy: got %b want 1", busy);
        end
        total++;
        if (readData[31:0] !== 32'h0) begin
            bad++; $display("FAIL busy_bypass_zero: got %h want 00000000", readData[31:0]);
        end
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        total++;
        if (cycles != 31 || busy !== 1'b0) begin
            bad++; $display("FAIL clear_length: got %0d cycles busy=%b want 31 busy=0", cycles, busy);
        end
        for (int a = 1; a < 32; a++) begin
            set_read(5'(a), 5'(a));
            total++;
            if (readData !== 64'h0) begin
                bad++; $display("FAIL cleared_x%0d: got %h want 0", a, readData);
            end
        end
        set_read(5'd5, 5'd0);
        total++;
        if (readData[31:0] !== 32'h0) begin
            bad++; $display("FAIL x5_write_during_busy: got %h want 00000000", readData[31:0]);
        end
    endtask

    task automatic test_dual_write();
        set_write(2'b11, 5'd3, 32'h11111111, 5'd4, 32'h22222222);
        tick();
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_read(5'd3, 5'd4);
        total++;
        if (readData !== {32'h22222222, 32'h11111111}) begin
            bad++; $display("FAIL dual_write_a: got %h want 2222222211111111", readData);
        end
        set_read(5'd4, 5'd3);
        total++;
        if (readData !== {32'h11111111, 32'h22222222}) begin
            bad++; $display("FAIL dual_write_b: got %h want 1111111122222222", readData);
        end
    endtask

    task automatic test_collision();
        set_write(2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h0000BBBB);
        set_read(5'd7, 5'd7);
        total++;
        if (readData !== {32'h0000BBBB, 32'h0000BBBB}) begin
            bad++; $display("FAIL collision_bypass: got %h want 0000bbbb0000bbbb", readData);
        end
        tick();
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_read(5'd7, 5'd3);
        total++;
        if (readData !== {32'h11111111, 32'h0000BBBB}) begin
            bad++; $display("FAIL collision_commit: got %h want 111111110000bbbb", readData);
        end
    endtask

    task automatic test_bypass();
        set_read(5'd9, 5'd4);
        total++;
        if (readData[31:0] !== 32'h0) begin
            bad++; $display("FAIL x9_before: got %h want 00000000", readData[31:0]);
        end
        set_write(2'b01, 5'd9, 32'h12345678, 5'd0, 32'h0);
        #1;
        total++;
        if (readData !== {32'h22222222, 32'h12345678}) begin
            bad++; $display("FAIL bypass_same_cycle: got %h want 2222222212345678", readData);
        end
        tick();
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        total++;
        if (readData[31:0] !== 32'h12345678) begin
            bad++; $display("FAIL bypass_retained: got %h want 12345678", readData[31:0]);
        end
    endtask

    task automatic test_x0();
        set_write(2'b10, 5'd9, 32'h0, 5'd0, 32'hFFFFFFFF);
        writeEnable = 2'b10;
        set_read(5'd0, 5'd9);
        total++;
        if (readData !== {32'h12345678, 32'h0}) begin
            bad++; $display("FAIL x0_bypass: got %h want 1234567800000000", readData);
        end
        tick();
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_read(5'd0, 5'd0);
        total++;
        if (readData !== 64'h0) begin
            bad++; $display("FAIL x0_stored: got %h want 0", readData);
        end
    endtask

    task automatic test_back_to_back();
        set_write(2'b01, 5'd1, 32'h00000001, 5'd0, 32'h0);
        tick();
        set_write(2'b11, 5'd1, 32'h00000002, 5'd2, 32'h00000003);
        set_read(5'd1, 5'd2);
        total++;
        if (readData !== {32'h00000003, 32'h00000002}) begin
            bad++; $display("FAIL b2b_bypass: got %h want 0000000300000002", readData);
        end
        tick();
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        total++;
        if (readData !== {32'h00000003, 32'h00000002}) begin
            bad++; $display("FAIL b2b_commit: got %h want 0000000300000002", readData);
        end
    endtask

    task automatic test_mid_clear();
        int cycles;
        set_write(2'b11, 5'd10, 32'h5, 5'd20, 32'h6);
        tick();
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_read(5'd10, 5'd20);
        total++;
        if (readData !== {32'h6, 32'h5}) begin
            bad++; $display("FAIL mid_clear_setup: got %h want 0000000600000005", readData);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (12) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL mid_clear_busy12: got %b want 1", busy);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        total++;
        if (cycles != 31 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_clear_length: got %0d cycles busy=%b want 31 busy=0", cycles, busy);
        end
        set_read(5'd10, 5'd20);
        total++;
        if (readData !== 64'h0) begin
            bad++; $display("FAIL mid_clear_regs: got %h want 0", readData);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        readAddr = '0;
        set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        test_reset();
        test_dual_write();
        test_collision();
        test_bypass();
        test_x0();
        test_back_to_back();
        test_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
